// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit:
// ALUOp codes, opcodes, FSM states and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [5:0] ALU_ZER   = 6'h00;
   localparam logic [5:0] ALU_SUB   = 6'h01;
   localparam logic [5:0] ALU_SLL   = 6'h02;
   localparam logic [5:0] ALU_ADD   = 6'h04;
   localparam logic [5:0] ALU_AND   = 6'h08;
   localparam logic [5:0] ALU_OR    = 6'h10;
   localparam logic [5:0] ALU_R_TYP = 6'h20;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_JR, S_I_EXEC, S_I_WB
   } state_t;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_RS     = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       alu_src_a;
      logic       ext_zero;
      logic       illegal;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [5:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
         OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational Moore output decoder: state (qualified by opcode and
// mem_ready) to the full datapath control vector.
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  logic [3:0]        state,
   input  logic [5:0]        opcode,
   input  logic              mem_ready,
   output logic [CTRL_W-1:0] ctrl
);

   state_t st;
   ctrl_t  c;

   assign st   = state_t'(state);
   assign ctrl = c;

   always_comb begin
      c        = '0;
      c.alu_op = ALU_ZER;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_4;
            c.alu_op    = ALU_ADD;
            c.ir_write  = mem_ready;
            c.pc_write  = mem_ready;
            c.pc_source = PCS_ALU;
         end
         S_DECODE: begin
            // Branch target is precomputed here while the opcode is decoded.
            c.alu_src_b = SRCB_IMM_SH;
            c.alu_op    = ALU_ADD;
            c.illegal   = !is_legal_op(opcode);
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RD_RT;
            c.mem_to_reg = M2R_MDR;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_R_TYP;
         end
         S_R_WB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RD_RD;
            c.mem_to_reg = M2R_ALU;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCS_ALUOUT;
            c.branch_ne     = (opcode == OP_BNE);
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCS_JUMP;
            if (opcode == OP_JAL) begin
               c.reg_write  = 1'b1;
               c.reg_dst    = RD_RA;
               c.mem_to_reg = M2R_PC;
            end
         end
         S_JR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_R_TYP;
            c.pc_write  = 1'b1;
            c.pc_source = PCS_RS;
         end
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            case (opcode)
               OP_ADDI: c.alu_op = ALU_ADD;
               OP_ANDI: begin
                  c.alu_op   = ALU_AND;
                  c.ext_zero = 1'b1;
               end
               OP_ORI: begin
                  c.alu_op   = ALU_OR;
                  c.ext_zero = 1'b1;
               end
               OP_LUI:  c.alu_op = ALU_SLL;
               default: c.alu_op = ALU_ZER;
            endcase
         end
         S_I_WB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RD_RT;
            c.mem_to_reg = M2R_ALU;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main control FSM: state register and next-state logic,
// with datapath strobes produced by mips_ctrl_outdec.
module mips_main_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               branch_ne,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic               ext_zero,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_source,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);

   state_t            state_reg;
   state_t            state_next;
   logic [CTRL_W-1:0] ctrl_vec;
   ctrl_t             ctrl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = S_IDLE;
      case (state_reg)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                         state_next = (funct == FUNCT_JR) ? S_JR : S_R_EXEC;
               OP_J, OP_JAL:                     state_next = S_JUMP;
               OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
               OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
               default:                          state_next = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    state_next = S_R_WB;
         S_I_EXEC:    state_next = S_I_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JR, S_I_WB: state_next = S_FETCH;
         default:     state_next = S_IDLE;
      endcase
   end

   mips_ctrl_outdec u_outdec (
      .state     (state_reg),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_vec)
   );

   assign ctrl          = ctrl_t'(ctrl_vec);
   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign branch_ne     = ctrl.branch_ne;
   assign iord          = ctrl.iord;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign ext_zero      = ctrl.ext_zero;
   assign illegal       = ctrl.illegal;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign alu_src_b     = ctrl.alu_src_b;
   assign pc_source     = ctrl.pc_source;
   assign alu_op        = ALUOP_W'(ctrl.alu_op);
   assign state_o       = STATE_W'(state_reg);

endmodule

// File: doc/mips_main_control_fsm.md
Name: mips_main_control_fsm

Overview:
- Multicycle MIPS main control unit. It is the producer side of the ALUOp interface: it decodes the instruction opcode and funct and sequences fetch/decode/execute/memory/writeback.
- Each state drives datapath strobes plus the one-hot ALUOp code consumed by the ALU control decoder.
- Sits between the instruction register and the datapath muxes/enables; a variable-latency memory stalls it through a ready handshake.

Parameters:
- ALUOP_W, 6, width of the ALUOp bus.
- STATE_W, 4, width of the state register and the debug state port.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26], stable from DECODE through end of instruction.
- funct  input  6  IR[5:0], used only to detect JR (0x08).
- mem_ready  input  1  memory completed the current read/write this cycle.
- pc_write, pc_write_cond, branch_ne  output  1 each  PC update controls.
- iord, mem_read, mem_write, ir_write  output  1 each  memory/IR controls.
- reg_write, alu_src_a, ext_zero  output  1 each.
- reg_dst  output  2  00=rt, 01=rd, 10=$31.
- mem_to_reg  output  2  00=ALUOut, 01=MDR, 10=PC.
- alu_src_b  output  2  00=B, 01=const 4, 10=imm, 11=imm<<2.
- pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target, 11=rs.
- alu_op  output  ALUOP_W  0x00 ZER, 0x01 SUB, 0x02 SLL, 0x04 ADD, 0x08 AND, 0x10 OR, 0x20 R_TYP.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state_o  output  STATE_W  current state, for debug.

Behaviour:
- Outputs are Moore decodes of the registered state, qualified by opcode/mem_ready where stated. Any signal not listed for a state is 0.
- States (in encoding order): IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, JR, I_EXEC, I_WB.
- Reset asserted (any time, including mid-instruction): state = IDLE immediately; all outputs 0, alu_op = ZER.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - ir_write=pc_write=mem_ready; pc_source=00.
  - Holds in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD. Next state by opcode:
  - 0x00 and funct=0x08 -> JR; other 0x00 -> R_EXEC.
  - 0x02/0x03 -> JUMP.
  - 0x04/0x05 -> BRANCH.
  - 0x08/0x0C/0x0D/0x0F -> I_EXEC.
  - 0x23/0x2B -> MEM_ADDR.
  - Else: illegal=1 for this cycle, -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; -> MEM_READ if 0x23, else -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; waits for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
- MEM_WRITE: mem_write=1, iord=1; waits for mem_ready, then -> FETCH. mem_write stays high while waiting.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=R_TYP; -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01, branch_ne=(opcode==0x05); -> FETCH.
- JUMP: pc_write=1, pc_source=10. If opcode=0x03, also reg_write=1, reg_dst=10, mem_to_reg=10. -> FETCH.
- JR: alu_src_a=1, alu_src_b=00, alu_op=R_TYP, pc_write=1, pc_source=11; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. Per opcode:
  - 0x08: alu_op=ADD.
  - 0x0C: alu_op=AND, ext_zero=1.
  - 0x0D: alu_op=OR, ext_zero=1.
  - 0x0F: alu_op=SLL (the ALU control forces shamt=16 for LUI).
  - -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; -> FETCH.
- Latency with mem_ready always 1: R/ADDI/SW = 4 cycles, LW = 5, BEQ/BNE/J/JAL/JR = 3.
- Unreachable state encodings -> IDLE.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - ALUOp localparams (ZER/SUB/SLL/ADD/AND/OR/R_TYP).
  - Opcode constants (RTYPE, J, JAL, BEQ, BNE, ADDI, ANDI, ORI, LUI, LW, SW).
  - FUNCT_JR.
  - State encodings.
  - Mux-select encodings for reg_dst, mem_to_reg, alu_src_b, pc_source.
- One optional sub-module: `mips_ctrl_outdec`, a purely combinational state+opcode -> control-vector decoder. Next-state logic and the state register stay in the top module.

Test Plan:
- Reset low mid-LW (state MEM_READ), then release -> state_o=IDLE asynchronously with all outputs 0; then FETCH with mem_read=1, alu_op=0x04.
- R-type add (opcode 0x00, funct 0x20), mem_ready=1 -> FETCH, DECODE, R_EXEC (alu_op=0x20), R_WB (reg_write=1, reg_dst=01); back in FETCH after 4 cycles.
- LW (0x23) with mem_ready low for 3 cycles in MEM_READ -> state holds, mem_read=1, iord=1 throughout; MEM_WB asserts reg_write=1, mem_to_reg=01; 8 cycles total.
- BNE (0x05) -> BRANCH with alu_op=0x01, pc_write_cond=1, branch_ne=1, pc_source=01; 3 cycles. Repeat with BEQ -> branch_ne=0.
- LUI (0x0F) -> I_EXEC alu_op=0x02, alu_src_b=10. ORI (0x0D) -> alu_op=0x10, ext_zero=1. JR (0x00/0x08) -> JR with pc_source=11, pc_write=1, never R_WB.
- Opcode 0x3F -> illegal=1 for exactly the DECODE cycle, next state FETCH, no reg_write/mem_write asserted. JAL (0x03) -> reg_dst=10, mem_to_reg=10, pc_source=10.
